edge_cfg_sequencer: RTL and testbench

//  Frame-synchronous configuration controller for the edge-detect stream filter. The host writes

---
 rtl/edge_cfg_sequencer.sv | 148 ++++++++++++++
 tb/tb_edge_cfg_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_cfg_sequencer.sv
// rtl/edge_cfg_sequencer.sv - frame-synchronous shadow-register replay into the edge-detect filter
module edge_cfg_sequencer #(
  parameter int NREG  = 4,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        h_chipselect,
  input  logic        h_read,
  input  logic        h_write,
  input  logic [2:0]  h_address,
  input  logic [31:0] h_writedata,
  output logic [31:0] h_readdata,
  input  logic        vid_valid,
  input  logic        vid_ready,
  input  logic        vid_sop,
  input  logic        vid_eop,
  output logic        vid_hold,
  output logic        m_chipselect,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  output logic        mode
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {GAP = 2'd0, FRAME = 2'd1, WRITE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [31:0]      shadow [NREG];
  logic [31:0]      snap   [NREG];
  logic [IW-1:0]    idx;
  logic             pending, err, mode_sh, snap_mode;
  logic [CNT_W-1:0] count;
  logic             beat, host_wr, host_rd, ctrl_wr, in_write;
  logic             start, finish, cnt_inc, err_set;
  logic [31:0]      status_w;

  assign host_wr  = h_chipselect & h_write;
  assign host_rd  = h_chipselect & h_read;
  assign ctrl_wr  = host_wr & (h_address == 3'd0);
  assign in_write = (state == WRITE);
  assign vid_hold = in_write | ((state == GAP) & pending);
  assign beat     = vid_valid & vid_ready & ~vid_hold;

  // Master port is idle (all zero) whenever no replay is running.
  assign m_chipselect = in_write;
  assign m_write      = in_write;
  assign m_address    = in_write ? 3'(idx) : 3'd0;
  assign m_writedata  = in_write ? snap[idx] : 32'd0;

  always_comb begin
    status_w             = '0;
    status_w[16 +: CNT_W] = count;
    status_w[2]          = err;
    status_w[1]          = in_write;
    status_w[0]          = pending;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= GAP;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    finish   = 1'b0;
    cnt_inc  = 1'b0;
    err_set  = 1'b0;
    case (state)
      GAP: begin
        if (pending) begin
          state_nx = WRITE;
          start    = 1'b1;
        end else if (beat & vid_sop & ~vid_eop) begin
          state_nx = FRAME;
        end else if (beat & vid_sop & vid_eop) begin
          cnt_inc = 1'b1;
        end else if (beat & vid_eop) begin
          err_set = 1'b1;
        end
      end
      FRAME: begin
        if (beat & vid_eop) begin
          state_nx = GAP;
          cnt_inc  = 1'b1;
        end else if (beat & vid_sop) begin
          err_set = 1'b1;
        end
      end
      WRITE: begin
        if (idx == IW'(NREG - 1)) begin
          state_nx = GAP;
          finish   = 1'b1;
        end
      end
      default: state_nx = GAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      err        <= 1'b0;
      mode_sh    <= 1'b0;
      snap_mode  <= 1'b0;
      mode       <= 1'b0;
      count      <= '0;
      idx        <= '0;
      h_readdata <= 32'd0;
      for (int i = 0; i < NREG; i++) begin
        shadow[i] <= 32'd0;
        snap[i]   <= 32'd0;
      end
    end else begin
      // A commit landing on the final replay cycle must survive the clear.
      if (ctrl_wr && h_writedata[0]) pending <= 1'b1;
      else if (finish)               pending <= 1'b0;

      if (ctrl_wr) mode_sh <= h_writedata[1];

      if (err_set)                    err <= 1'b1;
      else if (ctrl_wr && h_writedata[2]) err <= 1'b0;

      if (cnt_inc) count <= count + 1'b1;

      if (start || finish) idx <= '0;
      else if (in_write)   idx <= idx + IW'(1);

      if (start) begin
        snap_mode <= mode_sh;
        for (int i = 0; i < NREG; i++) snap[i] <= shadow[i];
      end

      if (finish) mode <= snap_mode;

      for (int i = 0; i < NREG; i++)
        if (host_wr && (h_address == 3'(i + 2))) shadow[i] <= h_writedata;

      if (host_rd) begin
        if (h_address == 3'd0)      h_readdata <= {30'd0, mode_sh, pending};
        else if (h_address == 3'd1) h_readdata <= status_w;
        else                        h_readdata <= 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_edge_cfg_sequencer.sv
// tb/tb_edge_cfg_sequencer.sv - randomized self-checking bench for edge_cfg_sequencer
module tb_edge_cfg_sequencer;
  localparam int NREG  = 4;
  localparam int CNT_W = 16;

  typedef logic [31:0] regs_t [NREG];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        h_chipselect = 1'b0, h_read = 1'b0, h_write = 1'b0;
  logic [2:0]  h_address = 3'd0;
  logic [31:0] h_writedata = 32'd0;
  logic [31:0] h_readdata;
  logic        vid_valid = 1'b0, vid_ready = 1'b0, vid_sop = 1'b0, vid_eop = 1'b0;
  logic        vid_hold, m_chipselect, m_write, mode;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;

  edge_cfg_sequencer #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .h_chipselect(h_chipselect), .h_read(h_read), .h_write(h_write),
    .h_address(h_address), .h_writedata(h_writedata), .h_readdata(h_readdata),
    .vid_valid(vid_valid), .vid_ready(vid_ready), .vid_sop(vid_sop), .vid_eop(vid_eop),
    .vid_hold(vid_hold), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .mode(mode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference state: what the host has programmed and what the filter should now hold.
  regs_t m_shadow;
  logic  m_mode_sh, m_mode, m_err;
  int    m_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_host();
    h_chipselect = 1'b0;
    h_write      = 1'b0;
    h_read       = 1'b0;
  endtask

  task automatic set_wr(input logic [2:0] a, input logic [31:0] d);
    h_chipselect = 1'b1;
    h_write      = 1'b1;
    h_address    = a;
    h_writedata  = d;
    if (a == 3'd0) begin
      m_mode_sh = d[1];
      if (d[2]) m_err = 1'b0;
    end else if (int'(a) >= 2 && int'(a) <= NREG + 1) begin
      m_shadow[int'(a) - 2] = d;
    end
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
    set_wr(a, d);
    tick();
    clr_host();
  endtask

  task automatic host_rd(input logic [2:0] a, output logic [31:0] d);
    h_chipselect = 1'b1;
    h_read       = 1'b1;
    h_address    = a;
    tick();
    clr_host();
    d = h_readdata;
  endtask

  function automatic logic [31:0] exp_status(input logic pend, input logic wr);
    exp_status = {16'(m_count), 13'd0, m_err, wr, pend};
  endfunction

  // Positioned at the cycle after the commit (or after eop) was captured.
  task automatic check_replay(input regs_t snap, input logic old_mode, input logic new_mode);
    logic [38:0] obs, expv;
    bit wr;
    for (int k = 1; k <= NREG + 2; k++) begin
      @(negedge clk);
      wr   = (k >= 2) && (k <= NREG + 1);
      expv = {(k <= NREG + 1), wr, wr, wr ? 3'(k - 2) : 3'd0,
              wr ? snap[wr ? k - 2 : 0] : 32'd0, (k == NREG + 2) ? new_mode : old_mode};
      obs  = {vid_hold, m_chipselect, m_write, m_address, m_writedata, mode};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL replay k=%0d: got hold/cs/wr/addr/data/mode=%h, want %h", k, obs, expv);
      end
      tick();
    end
  endtask

  // Streams one frame of len accepted beats; optionally commits while beat commit_beat is offered.
  task automatic send_frame(input int len, input int commit_beat, input logic cmode);
    int  b = 0;
    int  cyc = 0;
    bit  done = 0;
    bit  committed = 0;
    logic v, r;
    while (!done && cyc < 2000) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 4) != 0);
      if (commit_beat >= 0 && b == commit_beat && !committed) begin
        v = 1'b1;
        r = 1'b1;
        committed = 1;
        set_wr(3'd0, {30'd0, cmode, 1'b1});
      end
      vid_valid = v;
      vid_ready = r;
      vid_sop   = (b == 0);
      vid_eop   = (b == len - 1);
      @(negedge clk);
      n_cmp++;
      if ({vid_hold, m_write, m_chipselect} !== 3'b000) begin
        n_fail++;
        $display("FAIL frame_no_hold beat=%0d: got hold/wr/cs=%b, want 000", b, {vid_hold, m_write, m_chipselect});
      end
      tick();
      clr_host();
      if (v && r) begin
        if (b == len - 1) done = 1;
        b++;
      end
      cyc++;
    end
    vid_valid = 1'b0;
    vid_sop   = 1'b0;
    vid_eop   = 1'b0;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL frame_timeout: got %0d beats, want %0d", b, len);
    end
    m_count++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({vid_hold, m_chipselect, m_write, m_address, m_writedata, mode, h_readdata} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got hold=%b cs=%b wr=%b addr=%0d data=%h mode=%b rd=%h, want all 0",
               vid_hold, m_chipselect, m_write, m_address, m_writedata, mode, h_readdata);
    end
    reset_n = 1'b1;
    tick();
    host_rd(3'd0, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h, want 0", d); end
    host_rd(3'd1, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h, want 0", d); end
  endtask

  task automatic test_idle_replay();
    logic [31:0] d;
    logic nm;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NREG; i++)
        host_wr(3'(i + 2), (it == 0) ? 32'(32'h11 * (i + 1)) : $urandom);
      nm = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      set_wr(3'd0, {30'd0, nm, 1'b1});
      @(negedge clk);
      n_cmp++;
      if ({vid_hold, m_write} !== 2'b00) begin
        n_fail++;
        $display("FAIL commit_cycle it=%0d: got hold/wr=%b, want 00", it, {vid_hold, m_write});
      end
      tick();
      clr_host();
      check_replay(m_shadow, m_mode, nm);
      m_mode = nm;
      host_rd(3'd1, d);
      n_cmp++;
      if (d !== exp_status(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL idle_status it=%0d: got %h, want %h", it, d, exp_status(1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_midframe();
    logic [31:0] d;
    logic nm;
    int len;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < NREG; i++) host_wr(3'(i + 2), $urandom);
      len = (it == 0) ? 100 : $urandom_range(3, 60);
      nm  = 1'($urandom_range(0, 1));
      send_frame(len, $urandom_range(1, len - 1), nm);
      check_replay(m_shadow, m_mode, nm);
      m_mode = nm;
      host_rd(3'd1, d);
      n_cmp++;
      if (d !== exp_status(1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL midframe_status it=%0d: got %h, want %h", it, d, exp_status(1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_sop_commit();
    logic nm;
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < NREG; i++) host_wr(3'(i + 2), $urandom);
      nm = ~m_mode;
      send_frame($urandom_range(2, 40), 0, nm);
      check_replay(m_shadow, m_mode, nm);
      m_mode = nm;
    end
  endtask

  task automatic test_back_to_back();
    regs_t s1, s2;
    logic m1, m2, old;
    logic [38:0] obs, expv;
    bit w1, w2;
    int a;
    for (int i = 0; i < NREG; i++) host_wr(3'(i + 2), $urandom);
    m1  = 1'($urandom_range(0, 1));
    m2  = ~m1;
    old = m_mode;
    s1  = m_shadow;
    s2  = m_shadow;
    s2[0] = 32'h55;
    host_wr(3'd0, {30'd0, m1, 1'b1});
    for (int k = 1; k <= 2 * NREG + 3; k++) begin
      if (k == 3)        set_wr(3'd2, 32'h55);
      if (k == NREG + 1) set_wr(3'd0, {30'd0, m2, 1'b1});
      @(negedge clk);
      w1   = (k >= 2) && (k <= NREG + 1);
      w2   = (k >= NREG + 3) && (k <= 2 * NREG + 2);
      a    = w1 ? k - 2 : (w2 ? k - NREG - 3 : 0);
      expv = {(k <= 2 * NREG + 2), w1 | w2, w1 | w2, 3'(a),
              w1 ? s1[a] : (w2 ? s2[a] : 32'd0),
              (k < NREG + 2) ? old : ((k < 2 * NREG + 3) ? m1 : m2)};
      obs  = {vid_hold, m_chipselect, m_write, m_address, m_writedata, mode};
      n_cmp++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d: got %h, want %h", k, obs, expv);
      end
      tick();
      clr_host();
    end
    m_mode = m2;
  endtask

  task automatic test_error();
    logic [31:0] d;
    logic [2:0] pat [3];
    pat[0] = 3'b110; pat[1] = 3'b110; pat[2] = 3'b101;
    for (int i = 0; i < 3; i++) begin
      {vid_valid, vid_sop, vid_eop} = pat[i];
      vid_ready = 1'b1;
      tick();
    end
    vid_valid = 1'b0; vid_sop = 1'b0; vid_eop = 1'b0;
    m_err = 1'b1;
    m_count++;
    host_rd(3'd1, d);
    n_cmp++;
    if (d !== exp_status(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL sop_sop_eop_status: got %h, want %h", d, exp_status(1'b0, 1'b0));
    end
    host_wr(3'd0, {29'd0, 1'b1, m_mode_sh, 1'b0});
    host_rd(3'd1, d);
    n_cmp++;
    if (d !== exp_status(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL err_clear: got %h, want %h", d, exp_status(1'b0, 1'b0));
    end
    vid_valid = 1'b1; vid_eop = 1'b1;
    tick();
    vid_valid = 1'b0; vid_eop = 1'b0;
    m_err = 1'b1;
    host_rd(3'd1, d);
    n_cmp++;
    if (d !== exp_status(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL eop_in_gap: got %h, want %h", d, exp_status(1'b0, 1'b0));
    end
    host_wr(3'd0, {29'd0, 1'b1, m_mode_sh, 1'b0});
    host_wr(3'd7, $urandom);
    host_rd(3'd7, d);
    n_cmp++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h, want 0", d); end
    host_rd(3'd0, d);
    n_cmp++;
    if (d !== {30'd0, m_mode_sh, 1'b0}) begin
      n_fail++; $display("FAIL ctrl_read: got %h, want %h", d, {30'd0, m_mode_sh, 1'b0});
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    host_wr(3'd0, 32'h3);
    repeat (3) tick();
    n_cmp++;
    if ({m_write, m_address, m_writedata} !== {1'b1, 3'd2, m_shadow[2]}) begin
      n_fail++;
      $display("FAIL abort_idx2: got wr=%b addr=%0d data=%h, want 1 2 %h", m_write, m_address, m_writedata, m_shadow[2]);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({vid_hold, m_chipselect, m_write, m_address, m_writedata, mode} !== 39'd0) begin
      n_fail++;
      $display("FAIL abort_outputs: got hold=%b cs=%b wr=%b addr=%0d data=%h mode=%b, want all 0",
               vid_hold, m_chipselect, m_write, m_address, m_writedata, mode);
    end
    tick();
    reset_n = 1'b1;
    tick();
    m_count = 0; m_err = 1'b0; m_mode = 1'b0; m_mode_sh = 1'b0;
    for (int i = 0; i < NREG; i++) m_shadow[i] = 32'd0;
    host_rd(3'd0, d);
    n_cmp++;
    if ({d, mode} !== 33'd0) begin
      n_fail++; $display("FAIL abort_ctrl_mode: got ctrl=%h mode=%b, want 0 0", d, mode);
    end
    host_rd(3'd1, d);
    n_cmp++;
    if (d !== exp_status(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL abort_status: got %h, want %h", d, exp_status(1'b0, 1'b0));
    end
  endtask

  initial begin
    m_mode_sh = 1'b0; m_mode = 1'b0; m_err = 1'b0; m_count = 0;
    for (int i = 0; i < NREG; i++) m_shadow[i] = 32'd0;
    test_reset();
    test_idle_replay();
    test_midframe();
    test_sop_commit();
    test_back_to_back();
    test_error();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
